// File: rtl/axi_master128_if.sv
// AXI3-style 128-bit channel bundle between the axi_master128 traffic generator and a memory slave.
interface axi_master128_if #(
  parameter int ADDR_WIDTH = 40
);
  logic [ADDR_WIDTH-1:0] araddr_m0;
  logic [7:0]            arid_m0;
  logic [7:0]            arlen_m0;
  logic [2:0]            arsize_m0;
  logic [1:0]            arburst_m0;
  logic                  arvalid_m0;
  logic                  arready_m0;

  logic [ADDR_WIDTH-1:0] awaddr_m0;
  logic [7:0]            awid_m0;
  logic [7:0]            awlen_m0;
  logic [2:0]            awsize_m0;
  logic [1:0]            awburst_m0;
  logic                  awvalid_m0;
  logic                  awready_m0;

  logic [127:0]          wdata_m0;
  logic [15:0]           wstrb_m0;
  logic [7:0]            wid_m0;
  logic                  wlast_m0;
  logic                  wvalid_m0;
  logic                  wready_m0;

  logic [7:0]            bid_m0;
  logic [1:0]            bresp_m0;
  logic                  bvalid_m0;
  logic                  bready_m0;

  logic [127:0]          rdata_m0;
  logic [7:0]            rid_m0;
  logic [1:0]            rresp_m0;
  logic                  rlast_m0;
  logic                  rvalid_m0;
  logic                  rready_m0;

  modport master (
    output araddr_m0, arid_m0, arlen_m0, arsize_m0, arburst_m0, arvalid_m0,
    input  arready_m0,
    output awaddr_m0, awid_m0, awlen_m0, awsize_m0, awburst_m0, awvalid_m0,
    input  awready_m0,
    output wdata_m0, wstrb_m0, wid_m0, wlast_m0, wvalid_m0,
    input  wready_m0,
    input  bid_m0, bresp_m0, bvalid_m0,
    output bready_m0,
    input  rdata_m0, rid_m0, rresp_m0, rlast_m0, rvalid_m0,
    output rready_m0
  );

  modport slave (
    input  araddr_m0, arid_m0, arlen_m0, arsize_m0, arburst_m0, arvalid_m0,
    output arready_m0,
    input  awaddr_m0, awid_m0, awlen_m0, awsize_m0, awburst_m0, awvalid_m0,
    output awready_m0,
    input  wdata_m0, wstrb_m0, wid_m0, wlast_m0, wvalid_m0,
    output wready_m0,
    output bid_m0, bresp_m0, bvalid_m0,
    input  bready_m0,
    output rdata_m0, rid_m0, rresp_m0, rlast_m0, rvalid_m0,
    input  rready_m0
  );
endinterface

// File: rtl/axi_master128.sv
// 128-bit AXI traffic generator: one INCR burst per command, pattern write data, sticky error report.
// Define AXI_MASTER_RDCHK_EN to compare every read beat against the expected pattern.
module axi_master128 #(
  parameter int          ADDR_WIDTH = 40,
  parameter logic [31:0] PAT_STEP   = 32'h1
) (
  input  logic                  pll_core_cpuclk,
  input  logic                  pad_cpu_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [7:0]            cmd_id,
  input  logic [31:0]           cmd_seed,
  output logic                  done_valid,
  output logic                  done_error,
  output logic [7:0]            done_id,
  axi_master128_if.master       axi
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_AR, ST_RDATA, ST_AW, ST_WDATA, ST_BRESP, ST_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            id_q, id_d;
  logic [7:0]            beat_q, beat_d;
  logic [31:0]           pat_q, pat_d;
  logic                  err_q, err_d;

  logic last_beat;
  logic data_err;
  logic rd_err;

  assign last_beat = (beat_q == len_q);

`ifdef AXI_MASTER_RDCHK_EN
  assign data_err = (axi.rdata_m0 != {4{pat_q}});
`else
  assign data_err = 1'b0;
`endif

  assign rd_err = (axi.rresp_m0 != 2'b00) || (axi.rid_m0 != id_q) ||
                  (axi.rlast_m0 != last_beat) || data_err;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    id_d    = id_q;
    beat_d  = beat_q;
    pat_d   = pat_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          id_d    = cmd_id;
          pat_d   = cmd_seed;
          beat_d  = 8'd0;
          err_d   = 1'b0;
          state_d = cmd_write ? ST_AW : ST_AR;
        end
      end
      ST_AR:    if (axi.arready_m0) state_d = ST_RDATA;
      ST_RDATA: begin
        if (axi.rvalid_m0) begin
          beat_d = beat_q + 8'd1;
          pat_d  = pat_q + PAT_STEP;
          err_d  = err_q | rd_err;
          if (last_beat) state_d = ST_DONE;
        end
      end
      ST_AW:    if (axi.awready_m0) state_d = ST_WDATA;
      ST_WDATA: begin
        if (axi.wready_m0) begin
          beat_d = beat_q + 8'd1;
          pat_d  = pat_q + PAT_STEP;
          if (last_beat) state_d = ST_BRESP;
        end
      end
      ST_BRESP: begin
        if (axi.bvalid_m0) begin
          err_d   = err_q | (axi.bresp_m0 != 2'b00) | (axi.bid_m0 != id_q);
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Command fields are reset too, so the AXI address/id outputs start at known zeros.
  always_ff @(posedge pll_core_cpuclk) begin
    if (pad_cpu_rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= 8'd0;
      id_q    <= 8'd0;
      beat_q  <= 8'd0;
      pat_q   <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      id_q    <= id_d;
      beat_q  <= beat_d;
      pat_q   <= pat_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign done_valid = (state_q == ST_DONE);
  assign done_error = (state_q == ST_DONE) && err_q;
  assign done_id    = (state_q == ST_DONE) ? id_q : 8'd0;

  assign axi.araddr_m0  = addr_q;
  assign axi.arid_m0    = id_q;
  assign axi.arlen_m0   = len_q;
  assign axi.arsize_m0  = 3'b100;
  assign axi.arburst_m0 = 2'b01;
  assign axi.arvalid_m0 = (state_q == ST_AR);
  assign axi.rready_m0  = (state_q == ST_RDATA);

  assign axi.awaddr_m0  = addr_q;
  assign axi.awid_m0    = id_q;
  assign axi.awlen_m0   = len_q;
  assign axi.awsize_m0  = 3'b100;
  assign axi.awburst_m0 = 2'b01;
  assign axi.awvalid_m0 = (state_q == ST_AW);

  assign axi.wdata_m0   = {4{pat_q}};
  assign axi.wstrb_m0   = 16'hffff;
  assign axi.wid_m0     = id_q;
  assign axi.wlast_m0   = (state_q == ST_WDATA) && last_beat;
  assign axi.wvalid_m0  = (state_q == ST_WDATA);
  assign axi.bready_m0  = (state_q == ST_BRESP);

endmodule

// File: tb/tb_axi_master128.sv
// Bench for axi_master128: memory slave with stall/error knobs, a bus-level model checked every cycle, directed commands.
module tb_axi_master128;
  localparam int          AW   = 40;
  localparam logic [31:0] STEP = 32'h1;
`ifdef AXI_MASTER_RDCHK_EN
  localparam bit RDCHK = 1'b1;
`else
  localparam bit RDCHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len, cmd_id;
  logic [31:0]   cmd_seed;
  logic          done_valid, done_error;
  logic [7:0]    done_id;

  always #5 clk = ~clk;

  axi_master128_if #(.ADDR_WIDTH(AW)) bus ();

  axi_master128 #(.ADDR_WIDTH(AW), .PAT_STEP(STEP)) dut (
    .pll_core_cpuclk(clk), .pad_cpu_rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id), .cmd_seed(cmd_seed),
    .done_valid(done_valid), .done_error(done_error), .done_id(done_id),
    .axi(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave memory and behaviour knobs
  logic [127:0] mem [logic [35:0]];
  int           aw_stall_cfg = 0;
  bit           w_alt_cfg = 0;
  logic [1:0]   bresp_cfg = 2'b00;
  logic [7:0]   rid_xor_cfg = 8'h00;
  bit           rlast_early_cfg = 0;
  bit           stray_cfg = 0;

  function automatic logic [127:0] rd_mem(input logic [35:0] key);
    return mem.exists(key) ? mem[key] : 128'd0;
  endfunction

  // Memory slave: drive at the falling edge, then account for the handshakes the next rising edge will take.
  initial begin
    bit          r_act = 0, b_pend = 0, w_tog = 0;
    logic [35:0] r_base = '0, w_base = '0;
    logic [7:0]  r_len = '0, r_id = '0, b_id = '0, w_id = '0;
    int          r_n = 0, w_n = 0, aw_wait = 0;
    bus.arready_m0 = 0; bus.awready_m0 = 0; bus.wready_m0 = 0;
    bus.bvalid_m0 = 0; bus.bid_m0 = 0; bus.bresp_m0 = 0;
    bus.rvalid_m0 = 0; bus.rdata_m0 = 0; bus.rid_m0 = 0; bus.rresp_m0 = 0; bus.rlast_m0 = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        r_act = 0; b_pend = 0; aw_wait = 0; w_n = 0;
        bus.arready_m0 = 0; bus.awready_m0 = 0; bus.wready_m0 = 0;
        bus.bvalid_m0 = 0; bus.rvalid_m0 = 0; bus.rlast_m0 = 0;
      end else begin
        bus.arready_m0 = bus.arvalid_m0;
        bus.awready_m0 = bus.awvalid_m0 && (aw_wait >= aw_stall_cfg);
        bus.wready_m0  = w_alt_cfg ? w_tog : 1'b1;
        w_tog = ~w_tog;
        if (r_act) begin
          bus.rvalid_m0 = 1;
          bus.rdata_m0  = rd_mem(r_base + 36'(r_n));
          bus.rid_m0    = r_id ^ rid_xor_cfg;
          bus.rresp_m0  = 2'b00;
          bus.rlast_m0  = (r_n == int'(r_len)) || (rlast_early_cfg && r_n == 0);
        end else begin
          bus.rvalid_m0 = stray_cfg;
          bus.rdata_m0  = {4{32'hdead_beef}};
          bus.rid_m0    = 8'h00;
          bus.rresp_m0  = 2'b11;
          bus.rlast_m0  = stray_cfg;
        end
        if (b_pend) begin
          bus.bvalid_m0 = 1; bus.bid_m0 = b_id; bus.bresp_m0 = bresp_cfg;
        end else begin
          bus.bvalid_m0 = stray_cfg; bus.bid_m0 = 8'h00; bus.bresp_m0 = 2'b11;
        end

        if (bus.arvalid_m0 && bus.arready_m0) begin
          r_act = 1; r_base = bus.araddr_m0[39:4]; r_len = bus.arlen_m0; r_id = bus.arid_m0; r_n = 0;
        end
        if (r_act && bus.rvalid_m0 && bus.rready_m0) begin
          r_n++;
          if (r_n > int'(r_len)) r_act = 0;
        end
        if (bus.awvalid_m0) aw_wait++;
        if (bus.awvalid_m0 && bus.awready_m0) begin
          w_base = bus.awaddr_m0[39:4]; w_id = bus.awid_m0; w_n = 0; aw_wait = 0;
        end
        if (bus.wvalid_m0 && bus.wready_m0) begin
          mem[w_base + 36'(w_n)] = bus.wdata_m0;
          w_n++;
          if (bus.wlast_m0) begin b_pend = 1; b_id = w_id; end
        end
        if (b_pend && bus.bvalid_m0 && bus.bready_m0) b_pend = 0;
      end
    end
  end

  // Transaction-level model of the command in flight, observed from the bus
  bit           busy = 0, m_wr = 0, ar_done = 0, aw_done = 0, b_done = 0, m_err = 0;
  logic [AW-1:0] m_addr = '0;
  logic [7:0]   m_len = '0, m_id = '0;
  logic [31:0]  m_seed = '0;
  int           wn = 0, rn = 0, done_cnt = 0;
  bit           last_done_err = 0;
  logic [7:0]   last_done_id = '0;
  logic [127:0] wlog [$];

  function automatic logic [31:0] pat(input int n);
    return m_seed + 32'(n) * STEP;
  endfunction

  always begin
    bit fin, e_ar, e_aw, e_w, e_r, e_b, e_done;
    @(negedge clk);
    #1;
    if (rst) begin
      busy = 0;
    end else begin
      fin    = m_wr ? b_done : (rn > int'(m_len));
      e_ar   = busy && !m_wr && !ar_done;
      e_aw   = busy && m_wr && !aw_done;
      e_w    = busy && m_wr && aw_done && wn <= int'(m_len);
      e_r    = busy && !m_wr && ar_done && rn <= int'(m_len);
      e_b    = busy && m_wr && wn > int'(m_len) && !b_done;
      e_done = busy && fin;
      check("ctl", 160'({cmd_ready, bus.arvalid_m0, bus.awvalid_m0, bus.wvalid_m0,
                         bus.rready_m0, bus.bready_m0, done_valid}),
                   160'({!busy, e_ar, e_aw, e_w, e_r, e_b, e_done}));
      if (bus.arvalid_m0)
        check("ar", 160'({bus.araddr_m0, bus.arlen_m0, bus.arid_m0, bus.arsize_m0, bus.arburst_m0}),
                    160'({m_addr, m_len, m_id, 3'b100, 2'b01}));
      if (bus.awvalid_m0)
        check("aw", 160'({bus.awaddr_m0, bus.awlen_m0, bus.awid_m0, bus.awsize_m0, bus.awburst_m0}),
                    160'({m_addr, m_len, m_id, 3'b100, 2'b01}));
      if (bus.wvalid_m0)
        check("w", 160'({bus.wdata_m0, bus.wstrb_m0, bus.wid_m0, bus.wlast_m0}),
                   160'({{4{pat(wn)}}, 16'hffff, m_id, wn == int'(m_len)}));
      if (done_valid) begin
        check("done", 160'({done_id, done_error}), 160'({m_id, m_err}));
        done_cnt++;
        last_done_err = done_error;
        last_done_id  = done_id;
        busy = 0;
      end

      if (bus.arvalid_m0 && bus.arready_m0) ar_done = 1;
      if (bus.awvalid_m0 && bus.awready_m0) aw_done = 1;
      if (bus.rvalid_m0 && bus.rready_m0) begin
        if (bus.rresp_m0 != 2'b00 || bus.rid_m0 != m_id || bus.rlast_m0 != (rn == int'(m_len)) ||
            (RDCHK && bus.rdata_m0 != {4{pat(rn)}}))
          m_err = 1;
        rn++;
      end
      if (bus.wvalid_m0 && bus.wready_m0) begin
        wlog.push_back(bus.wdata_m0);
        wn++;
      end
      if (bus.bvalid_m0 && bus.bready_m0) begin
        b_done = 1;
        if (bus.bresp_m0 != 2'b00 || bus.bid_m0 != m_id) m_err = 1;
      end
      if (cmd_valid && cmd_ready) begin
        busy = 1; m_wr = cmd_write; m_addr = cmd_addr; m_len = cmd_len; m_id = cmd_id; m_seed = cmd_seed;
        ar_done = 0; aw_done = 0; b_done = 0; m_err = 0; wn = 0; rn = 0;
        wlog.delete();
      end
    end
  end

  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [7:0] l,
                       input logic [7:0] id, input logic [31:0] s);
    int i = 0;
    @(negedge clk);
    cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_id = id; cmd_seed = s; cmd_valid = 1;
    while (!cmd_ready && i < 50) begin
      @(negedge clk);
      i++;
    end
    check("cmd_accept", 160'(cmd_ready), 160'(1'b1));
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_done();
    int start = done_cnt;
    int i = 0;
    while (done_cnt == start && i < 2000) begin
      @(negedge clk);
      i++;
    end
    check("done_seen", 160'(done_cnt != start), 160'(1'b1));
  endtask

  task automatic run(input bit wr, input logic [AW-1:0] a, input logic [7:0] l,
                     input logic [7:0] id, input logic [31:0] s);
    issue(wr, a, l, id, s);
    wait_done();
  endtask

  task automatic check_reset_state(input string name);
    check(name, 160'({cmd_ready, bus.arvalid_m0, bus.awvalid_m0, bus.wvalid_m0, bus.rready_m0,
                      bus.bready_m0, done_valid, done_error, done_id}),
                160'({7'b1000000, 1'b0, 8'h00}));
  endtask

  initial begin
    logic [127:0] saved;
    int           start;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_id = '0; cmd_seed = '0;
    rst = 1;
    repeat (3) @(negedge clk);
    check_reset_state("reset_values");
    rst = 0;

    // Write 4 beats at 0x1000, seed 0x100
    run(1, 40'h1000, 8'd3, 8'h05, 32'h100);
    check("wr1_done", 160'({last_done_id, last_done_err}), 160'({8'h05, 1'b0}));
    check("wr1_beats", 160'(wlog.size()), 160'(4));
    check("wr1_beat0", 160'(wlog[0]), 160'(128'h00000100_00000100_00000100_00000100));
    check("wr1_beat3", 160'(wlog[3]), 160'(128'h00000103_00000103_00000103_00000103));
    check("wr1_mem1", 160'(rd_mem(36'h101)), 160'(128'h00000101_00000101_00000101_00000101));

    // Read back clean
    run(0, 40'h1000, 8'd3, 8'h06, 32'h100);
    check("rd1_done", 160'({last_done_id, last_done_err}), 160'({8'h06, 1'b0}));

    // Corrupted beat 2 is only visible with data checking
    saved = rd_mem(36'h102);
    mem[36'h102] = saved ^ 128'h1;
    run(0, 40'h1000, 8'd3, 8'h07, 32'h100);
    check("rd_corrupt_err", 160'(last_done_err), 160'(RDCHK));
    mem[36'h102] = saved;

    // Stalled AW and alternating wready, seed wrapping through zero
    aw_stall_cfg = 5; w_alt_cfg = 1;
    run(1, 40'h2000, 8'd3, 8'h08, 32'hffff_fffe);
    aw_stall_cfg = 0; w_alt_cfg = 0;
    check("stall_done", 160'({last_done_id, last_done_err}), 160'({8'h08, 1'b0}));
    check("stall_beats", 160'(wlog.size()), 160'(4));
    check("stall_wrap", 160'(wlog[2]), 160'(128'h0));
    check("stall_mem3", 160'(rd_mem(36'h203)), 160'({4{32'h1}}));

    // Single-beat write and read
    run(1, 40'h3000, 8'd0, 8'h09, 32'habcd_0000);
    check("len0_beats", 160'(wlog.size()), 160'(1));
    check("len0_data", 160'(wlog[0]), 160'({4{32'habcd_0000}}));
    run(0, 40'h3000, 8'd0, 8'h0a, 32'habcd_0000);
    check("len0_rd_err", 160'(last_done_err), 160'(1'b0));

    // 256-beat write and read
    run(1, 40'h10000, 8'd255, 8'h3c, 32'h55);
    check("len255_beats", 160'(wlog.size()), 160'(256));
    check("len255_mem_last", 160'(rd_mem(36'h10ff)), 160'({4{32'h154}}));
    run(0, 40'h10000, 8'd255, 8'h3d, 32'h55);
    check("len255_rd", 160'({last_done_id, last_done_err}), 160'({8'h3d, 1'b0}));

    // Error response, then the sticky flag must clear on the next command
    bresp_cfg = 2'b10;
    run(1, 40'h4000, 8'd1, 8'h11, 32'h7);
    bresp_cfg = 2'b00;
    check("bresp_err", 160'(last_done_err), 160'(1'b1));
    run(1, 40'h4000, 8'd1, 8'h12, 32'h7);
    check("bresp_clear", 160'(last_done_err), 160'(1'b0));

    // Wrong rid, then early rlast
    rid_xor_cfg = 8'h01;
    run(0, 40'h1000, 8'd3, 8'h13, 32'h100);
    rid_xor_cfg = 8'h00;
    check("rid_err", 160'(last_done_err), 160'(1'b1));
    rlast_early_cfg = 1;
    run(0, 40'h1000, 8'd1, 8'h14, 32'h100);
    rlast_early_cfg = 0;
    check("rlast_err", 160'(last_done_err), 160'(1'b1));

    // Stray responses while idle must be ignored
    start = done_cnt;
    stray_cfg = 1;
    repeat (5) @(negedge clk);
    stray_cfg = 0;
    repeat (2) @(negedge clk);
    check("stray_no_done", 160'(done_cnt), 160'(start));

    // Reset in the middle of a long read, then a clean command
    issue(0, 40'h10000, 8'd255, 8'h20, 32'h55);
    repeat (20) @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    check_reset_state("midburst_reset");
    rst = 0;
    run(0, 40'h1000, 8'd3, 8'h21, 32'h100);
    check("after_reset", 160'({last_done_id, last_done_err}), 160'({8'h21, 1'b0}));

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
